// File: rtl/pm_cycle.sv
// pm_cycle -- cycle controller for the P-M unit.
//
// Owns the START and WAIT control flip-flops and sequences each machine cycle
// through KC (cycle end) and PC (cycle start). At the last KC tick it latches
// the fetch (pr) / interrupt receive (przerw) decision. The block also provides
// a panel step budget, a bus-reply timeout with a sticky alarm, and
// parametrised KC/PC pulse lengths. The KC/PC pulses are timed by synchronous
// counters on __clk. Every output comes straight from a flop.
//
// Parameters:
//   KC_TICKS  length of the kc pulse in clocks (>= 1)
//   PC_TICKS  length of the pc pulse in clocks (>= 1)
//   STEP_W    width of the step budget counter
//   TO_TICKS  bus-reply timeout in clocks, 0 disables it
//
// Ports:
//   __clk, clm_          clock, asynchronous active-low reset
//   start_req, stop_req  panel START / STOP one-clock pulses
//   step_load, step_n    load step budget (also sets START)
//   hlt                  HLT executing, sampled at an accepted end-of-cycle
//   irq, irq_en          interrupt pending / acceptance allowed
//   ekc, got, ekc_fp     end-of-cycle request, bus reply, forced end-of-cycle
//   run, _wait           START & ~WAIT, WAIT flip-flop
//   kc, pc               cycle end / cycle start pulses
//   pr, przerw           decision latched at the end of KC
//   sp0, sp1, si1        state-entry strobes, valid during pc
//   steps_left           remaining step budget (0 = unlimited)
//   timeout              sticky bus-timeout alarm
//   busy                 sequencer is not idle
module pm_cycle #(
   parameter int KC_TICKS = 3,
   parameter int PC_TICKS = 2,
   parameter int STEP_W   = 8,
   parameter int TO_TICKS = 64
) (
   input  logic              __clk,
   input  logic              clm_,
   input  logic              start_req,
   input  logic              stop_req,
   input  logic              step_load,
   input  logic [STEP_W-1:0] step_n,
   input  logic              hlt,
   input  logic              irq,
   input  logic              irq_en,
   input  logic              ekc,
   input  logic              got,
   input  logic              ekc_fp,
   output logic              run,
   output logic              _wait,
   output logic              kc,
   output logic              pc,
   output logic              pr,
   output logic              przerw,
   output logic              sp0,
   output logic              sp1,
   output logic              si1,
   output logic [STEP_W-1:0] steps_left,
   output logic              timeout,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KC   = 2'd1,
      ST_PC   = 2'd2,
      ST_EXEC = 2'd3
   } state_t;

   localparam int TMAX = (KC_TICKS > PC_TICKS) ? KC_TICKS : PC_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int TOW  = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
   localparam bit TO_EN = (TO_TICKS > 0);

   localparam logic [TW-1:0]     TICK_ZERO = {TW{1'b0}};
   localparam logic [TW-1:0]     TICK_ONE  = TW'(1);
   localparam logic [TW-1:0]     KC_LAST   = TW'(KC_TICKS - 1);
   localparam logic [TW-1:0]     PC_LAST   = TW'(PC_TICKS - 1);
   localparam logic [TOW-1:0]    TO_ZERO   = {TOW{1'b0}};
   localparam logic [TOW-1:0]    TO_ONE    = TOW'(1);
   localparam logic [TOW-1:0]    TO_LAST   = TOW'((TO_TICKS > 0) ? (TO_TICKS - 1) : 0);
   localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

   state_t            state_r, state_s;
   logic [TW-1:0]     tick_r, tick_s;
   logic [TOW-1:0]    to_cnt_r, to_cnt_s;
   logic              pr_r, pr_s;
   logic              przerw_r, przerw_s;
   logic              start_r, start_s;
   logic              wait_r, wait_s;
   logic [STEP_W-1:0] steps_r, steps_s;
   logic              timeout_r, timeout_s;
   logic              run_r, kc_r, pc_r, sp0_r, sp1_r, si1_r, busy_r;
   logic              eoc_s, to_hit_s, dec_s;
   logic              dpr_s, dprz_s, stpc_s;

   // Request terms, taken from the registered control flip-flops.
   assign dpr_s  = start_r & ~wait_r;
   assign dprz_s = start_r & irq & irq_en;
   assign stpc_s = dpr_s | dprz_s;

   // Sequencer next state, pulse tick counter and bus-reply timeout counter.
   always_comb begin
      state_s  = state_r;
      tick_s   = tick_r;
      to_cnt_s = to_cnt_r;
      pr_s     = pr_r;
      przerw_s = przerw_r;
      eoc_s    = 1'b0;
      to_hit_s = 1'b0;
      dec_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (stpc_s) begin
               state_s = ST_KC;
               tick_s  = TICK_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_KC: begin
            if (tick_r == KC_LAST) begin
               pr_s     = dpr_s;
               przerw_s = dprz_s;
               state_s  = ST_PC;
               tick_s   = TICK_ZERO;
            end else begin
               tick_s = tick_r + TICK_ONE;
            end
         end
         ST_PC: begin
            if (tick_r == PC_LAST) begin
               tick_s   = TICK_ZERO;
               to_cnt_s = TO_ZERO;
               // Only fetch cycles consume budget; a zero budget means unlimited.
               dec_s    = pr_r & (steps_r != STEP_ZERO);
               if (pr_r | przerw_r) begin
                  state_s = ST_EXEC;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               tick_s = tick_r + TICK_ONE;
            end
         end
         ST_EXEC: begin
            if ((ekc & got) | ekc_fp) begin
               eoc_s   = 1'b1;
               state_s = ST_KC;
               tick_s  = TICK_ZERO;
            end else if (TO_EN && ekc && !got) begin
               // The counter only advances while a reply is actually awaited.
               if (to_cnt_r == TO_LAST) begin
                  eoc_s    = 1'b1;
                  to_hit_s = 1'b1;
                  state_s  = ST_KC;
                  tick_s   = TICK_ZERO;
               end else begin
                  to_cnt_s = to_cnt_r + TO_ONE;
               end
            end else begin
               to_cnt_s = to_cnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            tick_s  = TICK_ZERO;
         end
      endcase
   end

   // START/WAIT flip-flops, step budget and timeout alarm next values.
   always_comb begin
      // STOP beats START; a fresh load beats the final budget decrement.
      if (stop_req) begin
         start_s = 1'b0;
      end else if (start_req | step_load) begin
         start_s = 1'b1;
      end else if (dec_s && (steps_r == STEP_ONE)) begin
         start_s = 1'b0;
      end else begin
         start_s = start_r;
      end

      if (step_load) begin
         steps_s = step_n;
      end else if (dec_s) begin
         steps_s = steps_r - STEP_ONE;
      end else begin
         steps_s = steps_r;
      end

      // Clearing WAIT takes precedence over setting it on the same edge.
      if (si1_r | start_req | stop_req) begin
         wait_s = 1'b0;
      end else if (eoc_s & hlt) begin
         wait_s = 1'b1;
      end else begin
         wait_s = wait_r;
      end

      // A new timeout event is never lost to a coincident start_req.
      if (to_hit_s) begin
         timeout_s = 1'b1;
      end else if (start_req) begin
         timeout_s = 1'b0;
      end else begin
         timeout_s = timeout_r;
      end
   end

   // State, counters, control flip-flops and Moore outputs from next values.
   always_ff @(posedge __clk or negedge clm_) begin
      if (!clm_) begin
         state_r   <= ST_IDLE;
         tick_r    <= TICK_ZERO;
         to_cnt_r  <= TO_ZERO;
         pr_r      <= 1'b0;
         przerw_r  <= 1'b0;
         start_r   <= 1'b0;
         wait_r    <= 1'b0;
         steps_r   <= STEP_ZERO;
         timeout_r <= 1'b0;
         run_r     <= 1'b0;
         kc_r      <= 1'b0;
         pc_r      <= 1'b0;
         sp0_r     <= 1'b0;
         sp1_r     <= 1'b0;
         si1_r     <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         tick_r    <= tick_s;
         to_cnt_r  <= to_cnt_s;
         pr_r      <= pr_s;
         przerw_r  <= przerw_s;
         start_r   <= start_s;
         wait_r    <= wait_s;
         steps_r   <= steps_s;
         timeout_r <= timeout_s;
         run_r     <= start_s & ~wait_s;
         kc_r      <= (state_s == ST_KC);
         pc_r      <= (state_s == ST_PC);
         sp0_r     <= (state_s == ST_PC) & ~pr_s & ~przerw_s;
         sp1_r     <= (state_s == ST_PC) & pr_s & ~przerw_s;
         si1_r     <= (state_s == ST_PC) & przerw_s;
         busy_r    <= (state_s != ST_IDLE);
      end
   end

   assign run        = run_r;
   assign _wait      = wait_r;
   assign kc         = kc_r;
   assign pc         = pc_r;
   assign pr         = pr_r;
   assign przerw     = przerw_r;
   assign sp0        = sp0_r;
   assign sp1        = sp1_r;
   assign si1        = si1_r;
   assign steps_left = steps_r;
   assign timeout    = timeout_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_pm_cycle.sv
// tb_pm_cycle -- self-checking bench for pm_cycle.
//
// A phase/countdown model of the controller runs beside the DUT and is
// compared against every output on every falling clock edge. Directed
// scenarios (reset in PC, run loop, stop, interrupt, HLT wait, step budget,
// timeout) add hand-computed literal expectations; a randomized phase
// follows, with one asynchronous reset in the middle.
module tb_pm_cycle;
   localparam int KC_T = 3;
   localparam int PC_T = 2;
   localparam int SW   = 8;
   localparam int TO_T = 16;

   localparam int PH_IDLE = 0;
   localparam int PH_KC   = 1;
   localparam int PH_PC   = 2;
   localparam int PH_EXEC = 3;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b1;
   logic          start_req = 1'b0;
   logic          stop_req  = 1'b0;
   logic          step_load = 1'b0;
   logic [SW-1:0] step_n    = 8'd0;
   logic          hlt       = 1'b0;
   logic          irq       = 1'b0;
   logic          irq_en    = 1'b0;
   logic          ekc       = 1'b0;
   logic          got       = 1'b0;
   logic          ekc_fp    = 1'b0;
   logic          run, wait_o, kc, pc, pr, przerw, sp0, sp1, si1, timeout, busy;
   logic [SW-1:0] steps_left;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   int m_phase = PH_IDLE;
   int m_left  = 0;
   int m_age   = 0;
   int m_steps = 0;
   bit m_pr = 1'b0, m_przerw = 1'b0, m_start = 1'b0, m_wait = 1'b0, m_to = 1'b0;

   pm_cycle #(.KC_TICKS(KC_T), .PC_TICKS(PC_T), .STEP_W(SW), .TO_TICKS(TO_T)) dut (
      .__clk(clk), .clm_(rst_n), .start_req(start_req), .stop_req(stop_req),
      .step_load(step_load), .step_n(step_n), .hlt(hlt), .irq(irq), .irq_en(irq_en),
      .ekc(ekc), .got(got), .ekc_fp(ekc_fp), .run(run), ._wait(wait_o), .kc(kc),
      .pc(pc), .pr(pr), .przerw(przerw), .sp0(sp0), .sp1(sp1), .si1(si1),
      .steps_left(steps_left), .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: advances once per rising edge, resets asynchronously.
   initial begin : model
      bit run_now, dprz, eoc, hit, dec, si1_now;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = PH_IDLE; m_left = 0; m_age = 0; m_steps = 0;
            m_pr = 1'b0; m_przerw = 1'b0; m_start = 1'b0; m_wait = 1'b0; m_to = 1'b0;
         end else begin
            run_now = m_start && !m_wait;
            dprz    = m_start && irq && irq_en;
            si1_now = (m_phase == PH_PC) && m_przerw;
            eoc = 1'b0; hit = 1'b0; dec = 1'b0;
            case (m_phase)
               PH_IDLE: if (run_now || dprz) begin m_phase = PH_KC; m_left = KC_T; end
               PH_KC: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_pr = run_now; m_przerw = dprz; m_phase = PH_PC; m_left = PC_T;
                  end
               end
               PH_PC: begin
                  m_left--;
                  if (m_left == 0) begin
                     dec = m_pr && (m_steps != 0);
                     m_phase = (m_pr || m_przerw) ? PH_EXEC : PH_IDLE;
                     m_age = 0;
                  end
               end
               default: begin
                  if ((ekc && got) || ekc_fp) eoc = 1'b1;
                  else if (TO_T > 0 && ekc && !got) begin
                     m_age++;
                     if (m_age == TO_T) begin eoc = 1'b1; hit = 1'b1; end
                  end
               end
            endcase
            if (eoc) begin m_phase = PH_KC; m_left = KC_T; end
            if (stop_req) m_start = 1'b0;
            else if (start_req || step_load) m_start = 1'b1;
            else if (dec && m_steps == 1) m_start = 1'b0;
            if (step_load) m_steps = int'(step_n);
            else if (dec) m_steps = m_steps - 1;
            if (si1_now || start_req || stop_req) m_wait = 1'b0;
            else if (eoc && hlt) m_wait = 1'b1;
            if (hit) m_to = 1'b1;
            else if (start_req) m_to = 1'b0;
         end
      end
   end

   // Compare process: every output against the model on each falling edge.
   initial begin : compare
      logic [18:0] act_v, exp_v;
      forever begin
         @(negedge clk);
         act_v = {run, wait_o, kc, pc, pr, przerw, sp0, sp1, si1, busy, timeout, steps_left};
         exp_v = {m_start && !m_wait, m_wait, m_phase == PH_KC, m_phase == PH_PC, m_pr, m_przerw,
                  m_phase == PH_PC && !m_pr && !m_przerw, m_phase == PH_PC && m_pr && !m_przerw,
                  m_phase == PH_PC && m_przerw, m_phase != PH_IDLE, m_to, SW'(m_steps)};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wait_kc(input string name);
      int n;
      n = 0;
      while (!kc && n < 60) begin cyc(); n++; end
      if (!kc) begin
         checks++; errors++;
         $display("FAIL %s actual=no_kc required=kc within 60 clocks", name);
      end
   endtask

   // Waits for the next KC, then measures KC/PC length and strobe clocks.
   task automatic measure(input string name, output int kl, output int pl,
                          output int n0, output int n1, output int ni);
      wait_kc(name);
      kl = 0; pl = 0; n0 = 0; n1 = 0; ni = 0;
      while (kc && kl < 20) begin kl++; cyc(); end
      while (pc && pl < 20) begin
         pl++; n0 += int'(sp0); n1 += int'(sp1); ni += int'(si1);
         cyc();
      end
   endtask

   // STOP, then force every EXEC to end until the block is idle.
   task automatic to_idle(input string name);
      int n;
      stop_req = 1'b1; cyc(); stop_req = 1'b0;
      n = 0;
      while (busy && n < 60) begin ekc_fp = !kc && !pc; cyc(); n++; end
      ekc_fp = 1'b0;
      chk({name, "_idle"}, int'(busy), 0);
   endtask

   initial begin : stim
      int kl, pl, n0, n1, ni, n, rises, nseq;
      int sq[8];
      logic prev_sp1;
      logic [SW-1:0] last_steps;

      #1 rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      chk("reset_busy", int'(busy), 0);
      chk("reset_outs", int'({run, wait_o, kc, pc, pr, przerw, timeout}), 0);
      chk("reset_steps", int'(steps_left), 0);

      // Reset while in PC drops outputs asynchronously.
      start_req = 1'b1; cyc(); start_req = 1'b0;
      wait_kc("rst_pc");
      n = 0;
      while (!pc && n < 20) begin cyc(); n++; end
      chk("rst_pc_reached", int'(pc), 1);
      chk("rst_pc_sp1", int'(sp1), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_pc", int'(pc), 0);
      chk("rst_async_sp1", int'(sp1), 0);
      chk("rst_async_pr", int'(pr), 0);
      chk("rst_async_busy", int'(busy), 0);
      cyc(); rst_n = 1'b1;
      repeat (20) cyc();
      chk("rst_idle20", int'(busy), 0);

      // Run loop: ekc&got 4 clocks into EXEC; STOP mid-EXEC in the third cycle.
      start_req = 1'b1; cyc(); start_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         measure("run", kl, pl, n0, n1, ni);
         chk("run_kc_len", kl, 3);
         chk("run_pc_len", pl, 2);
         chk("run_sp1", n1, 2);
         for (int k = 1; k < 4; k++) begin
            stop_req = (c == 2 && k == 2);
            cyc();
         end
         stop_req = 1'b0;
         ekc = 1'b1; got = 1'b1; cyc(); ekc = 1'b0; got = 1'b0;
      end
      measure("stop", kl, pl, n0, n1, ni);
      chk("stop_sp0", n0, 2);
      chk("stop_sp1", n1, 0);
      chk("stop_idle", int'(busy), 0);
      chk("stop_run", int'(run), 0);

      // Interrupt raised during EXEC with run=1.
      start_req = 1'b1; cyc(); start_req = 1'b0;
      measure("irq0", kl, pl, n0, n1, ni);
      irq = 1'b1; irq_en = 1'b1;
      repeat (3) cyc();
      ekc = 1'b1; got = 1'b1; cyc(); ekc = 1'b0; got = 1'b0;
      measure("irq1", kl, pl, n0, n1, ni);
      chk("irq_si1", ni, 2);
      chk("irq_sp1", n1, 0);
      chk("irq_wait", int'(wait_o), 0);
      irq = 1'b0; irq_en = 1'b0;
      to_idle("irq");

      // HLT at an accepted end-of-cycle, then wake-up by interrupt.
      start_req = 1'b1; cyc(); start_req = 1'b0;
      measure("hlt0", kl, pl, n0, n1, ni);
      repeat (3) cyc();
      hlt = 1'b1; ekc = 1'b1; got = 1'b1; cyc(); hlt = 1'b0; ekc = 1'b0; got = 1'b0;
      chk("hlt_wait", int'(wait_o), 1);
      chk("hlt_run", int'(run), 0);
      measure("hlt1", kl, pl, n0, n1, ni);
      chk("hlt_sp0", n0, 2);
      chk("hlt_idle", int'(busy), 0);
      repeat (5) cyc();
      chk("hlt_still_idle", int'(busy), 0);
      irq = 1'b1; irq_en = 1'b1;
      measure("hlt_irq", kl, pl, n0, n1, ni);
      chk("hlt_irq_si1", ni, 2);
      chk("hlt_irq_wait", int'(wait_o), 0);
      irq = 1'b0; irq_en = 1'b0;
      to_idle("hlt");

      // Step budget of 3.
      step_n = 8'd3; step_load = 1'b1; cyc(); step_load = 1'b0;
      chk("step_loaded", int'(steps_left), 3);
      chk("step_run", int'(run), 1);
      rises = 0; nseq = 0; prev_sp1 = 1'b0; last_steps = steps_left;
      for (int k = 0; k < 200; k++) begin
         ekc_fp = busy && !kc && !pc;
         if (sp1 && !prev_sp1) rises++;
         prev_sp1 = sp1;
         if (steps_left != last_steps) begin
            if (nseq < 8) sq[nseq] = int'(steps_left);
            nseq++;
            last_steps = steps_left;
         end
         if (k > 2 && !busy) break;
         cyc();
      end
      ekc_fp = 1'b0;
      chk("step_sp1_count", rises, 3);
      chk("step_seq_len", nseq, 3);
      chk("step_seq0", sq[0], 2);
      chk("step_seq1", sq[1], 1);
      chk("step_seq2", sq[2], 0);
      chk("step_run_end", int'(run), 0);
      chk("step_idle", int'(busy), 0);

      // Bus-reply timeout.
      start_req = 1'b1; cyc(); start_req = 1'b0;
      measure("to0", kl, pl, n0, n1, ni);
      ekc = 1'b1; n = 0;
      while (!kc && n < 40) begin cyc(); n++; end
      ekc = 1'b0;
      chk("to_latency", n, 16);
      chk("to_alarm", int'(timeout), 1);
      to_idle("to");
      repeat (5) cyc();
      chk("to_sticky", int'(timeout), 1);
      start_req = 1'b1; cyc(); start_req = 1'b0;
      chk("to_cleared", int'(timeout), 0);
      to_idle("to2");

      // Randomized stimulus with one asynchronous reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         start_req = ($urandom_range(15) == 0);
         stop_req  = ($urandom_range(31) == 0);
         step_load = ($urandom_range(39) == 0);
         step_n    = SW'($urandom_range(4));
         hlt       = ($urandom_range(7) == 0);
         irq       = ($urandom_range(3) == 0);
         irq_en    = ($urandom_range(1) == 0);
         ekc       = ($urandom_range(1) == 0);
         got       = ($urandom_range(3) == 0);
         ekc_fp    = ($urandom_range(15) == 0);
         if (i == 1500) begin
            #2 rst_n = 1'b0;
            cyc();
            #2 rst_n = 1'b1;
         end
         cyc();
      end
      start_req = 1'b0; stop_req = 1'b0; step_load = 1'b0; hlt = 1'b0;
      irq = 1'b0; irq_en = 1'b0; ekc = 1'b0; got = 1'b0; ekc_fp = 1'b0;
      repeat (2) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
